counter_binary: RTL and testbench

//  Synchronous up/down binary counter with load, carry chain and overflow flags.

---
 rtl/counter_binary.sv | 60 ++++++
 tb/tb_counter_binary.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_binary.sv
// counter_binary: synchronous up/down binary counter with parallel load,
// exposed adder carry chain, carry-out and two's-complement overflow flags.
// Typical use is a FIFO address counter: run = increment strobe, and a load
// of zero at the last address gives modulo-N wrap.

module counter_binary #(
  // Width must be set by the instantiator; 4 is only a usable default.
  parameter int                    WORD_WIDTH    = 4,
  parameter logic [WORD_WIDTH-1:0] INCREMENT     = '0,
  parameter logic [WORD_WIDTH-1:0] INITIAL_COUNT = '0
) (
  input  logic                  i_clock,
  input  logic                  i_clear,
  input  logic                  i_up_down,
  input  logic                  i_run,
  input  logic                  i_load,
  input  logic [WORD_WIDTH-1:0] i_load_count,
  input  logic                  i_carry_in,
  output logic                  o_carry_out,
  output logic [WORD_WIDTH-1:0] o_carries,
  output logic                  o_overflow,
  output logic [WORD_WIDTH-1:0] o_count
);

  // Power-up value matches the post-clear value.
  logic [WORD_WIDTH-1:0] r_count = INITIAL_COUNT;

  logic [WORD_WIDTH-1:0] w_addend;
  logic                  w_lsb_carry;
  logic [WORD_WIDTH-1:0] w_next;
  logic                  w_carry_out;

  // Down counting reuses the same adder: count + ~INCREMENT + ~carry_in,
  // so carry_in acts as a borrow-in and carry_out as "no borrow".
  always_comb begin
    w_addend    = i_up_down ? ~INCREMENT   : INCREMENT;
    w_lsb_carry = i_up_down ? ~i_carry_in  : i_carry_in;
    {w_carry_out, w_next} = {1'b0, r_count}
                          + {1'b0, w_addend}
                          + {{WORD_WIDTH{1'b0}}, w_lsb_carry};
  end

  // Carry into each bit recovered from sum ^ operands; the MSB carry-in
  // against carry-out gives signed overflow. Valid every cycle.
  always_comb begin
    o_carries   = w_next ^ r_count ^ w_addend;
    o_carry_out = w_carry_out;
    o_overflow  = o_carries[WORD_WIDTH-1] ^ w_carry_out;
  end

  // Count register, priority clear > load > run > hold.
  always_ff @(posedge i_clock) begin
    if (i_clear)     r_count <= INITIAL_COUNT;
    else if (i_load) r_count <= i_load_count;
    else if (i_run)  r_count <= w_next;
  end

  assign o_count = r_count;

endmodule

// File: tb/tb_counter_binary.sv
// Bench for counter_binary: directed scenarios plus randomized cycles
// against an integer-arithmetic reference model.

module tb_counter_binary;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WORD_WIDTH=4, INCREMENT=1, INITIAL_COUNT=0
  logic       clear = 1'b0, up_down = 1'b0, run = 1'b0, load = 1'b0, carry_in = 1'b0;
  logic [3:0] load_count = '0;
  logic       carry_out, overflow;
  logic [3:0] carries, count;

  // DUT B: WORD_WIDTH=4, INCREMENT=3, INITIAL_COUNT=A
  logic       clear_b = 1'b0, up_down_b = 1'b0, run_b = 1'b0, load_b = 1'b0, carry_in_b = 1'b0;
  logic [3:0] load_count_b = '0;
  logic       carry_out_b, overflow_b;
  logic [3:0] carries_b, count_b;

  counter_binary #(.WORD_WIDTH(4), .INCREMENT(4'd1), .INITIAL_COUNT(4'd0)) dut (
    .i_clock(clk), .i_clear(clear), .i_up_down(up_down), .i_run(run),
    .i_load(load), .i_load_count(load_count), .i_carry_in(carry_in),
    .o_carry_out(carry_out), .o_carries(carries), .o_overflow(overflow),
    .o_count(count));

  counter_binary #(.WORD_WIDTH(4), .INCREMENT(4'd3), .INITIAL_COUNT(4'hA)) dut_b (
    .i_clock(clk), .i_clear(clear_b), .i_up_down(up_down_b), .i_run(run_b),
    .i_load(load_b), .i_load_count(load_count_b), .i_carry_in(carry_in_b),
    .o_carry_out(carry_out_b), .o_carries(carries_b), .o_overflow(overflow_b),
    .o_count(count_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the spec's rules.
  // carries[i] = carry (up) / no-borrow (down) out of the low i bits.
  function automatic void model(input int c, input int inc, input bit ud, input bit cin,
                                output int nx, output bit co, output logic [3:0] cr,
                                output bit ov);
    int s, m, sc, si, ss;
    for (int i = 0; i < 4; i++) begin
      m = 1 << i;
      if (!ud) cr[i] = ((c % m) + (inc % m) + int'(cin)) >= m;
      else     cr[i] = ((c % m) - (inc % m) - int'(cin)) >= 0;
    end
    if (!ud) begin s = c + inc + int'(cin); co = (s >= 16); end
    else     begin s = c - inc - int'(cin); co = (s >= 0);  end
    nx = ((s % 16) + 16) % 16;
    sc = (c   >= 8) ? c   - 16 : c;
    si = (inc >= 8) ? inc - 16 : inc;
    ss = ud ? (sc - si - int'(cin)) : (sc + si + int'(cin));
    ov = (ss > 7) || (ss < -8);
  endfunction

  initial begin
    int exp_c, mc, nx;
    bit co, ov;
    logic [3:0] cr;

    #1;
    chk("powerup_a", count, 4'd0);
    chk("powerup_b", count_b, 4'hA);

    // 1: reset and hold
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear", count, 4'd0);
    repeat (10) tick();
    chk("hold", count, 4'd0);

    // 2: up count with natural wrap
    run = 1'b1; up_down = 1'b0; carry_in = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      if (i - 1 == 15) begin
        chk("cout_at_15", {3'b0, carry_out}, 4'd1);
        chk("ovf_at_15",  {3'b0, overflow},  4'd0);
      end
      if (i - 1 == 7) begin
        chk("ovf_at_7",      {3'b0, overflow}, 4'd1);
        chk("carries_at_7",  carries, 4'b1110);
        carry_in = 1'b1; #1;
        chk("carries_at_7_cin", carries, 4'b1111);
        chk("ovf_at_7_cin", {3'b0, overflow}, 4'd1);
        carry_in = 1'b0; #1;
      end
      tick();
      chk("up_seq", count, 4'(i % 16));
    end

    // 3: load then count down through zero
    run = 1'b0; load = 1'b1; load_count = 4'd2; tick(); load = 1'b0;
    chk("load_2", count, 4'd2);
    run = 1'b1; up_down = 1'b1;
    tick(); chk("down_1", count, 4'd1);
    tick(); chk("down_0", count, 4'd0);
    chk("borrow_at_0", {3'b0, carry_out}, 4'd0);
    tick(); chk("down_15", count, 4'd15);
    run = 1'b0; load = 1'b1; load_count = 4'd5; tick(); load = 1'b0;
    carry_in = 1'b1; run = 1'b1; tick(); run = 1'b0; carry_in = 1'b0;
    chk("down_borrow_in", count, 4'd3);

    // 4: priority
    clear = 1'b1; load = 1'b1; run = 1'b1; load_count = 4'd7; up_down = 1'b0;
    tick(); clear = 1'b0;
    chk("clear_wins", count, 4'd0);
    load_count = 4'd9; tick(); load = 1'b0; run = 1'b0;
    chk("load_over_run", count, 4'd9);

    // 5: modulo-5 wrap via external load of zero
    clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1; load_count = 4'd0; exp_c = 0;
    for (int i = 0; i < 7; i++) begin
      load = (exp_c == 4);
      tick();
      exp_c = (exp_c == 4) ? 0 : exp_c + 1;
      chk("mod5", count, 4'(exp_c));
    end
    load = 1'b0; run = 1'b0;

    // 6: non-default parameters
    clear_b = 1'b1; tick(); clear_b = 1'b0;
    chk("b_clear", count_b, 4'hA);
    run_b = 1'b1;
    tick(); chk("b_D", count_b, 4'hD);
    chk("b_cout_at_D", {3'b0, carry_out_b}, 4'd1);
    tick(); chk("b_0", count_b, 4'h0);
    tick(); chk("b_3", count_b, 4'h3);
    run_b = 1'b0;

    // Randomized cycles against the model
    clear = 1'b1; tick(); clear = 1'b0;
    mc = 0;
    for (int i = 0; i < 400; i++) begin
      clear      = ($urandom_range(0, 19) == 0);
      load       = ($urandom_range(0, 7)  == 0);
      run        = $urandom_range(0, 1);
      up_down    = $urandom_range(0, 1);
      carry_in   = $urandom_range(0, 1);
      load_count = 4'($urandom_range(0, 15));
      #1;
      model(mc, 1, up_down, carry_in, nx, co, cr, ov);
      chk("rnd_cout",    {3'b0, carry_out}, {3'b0, co});
      chk("rnd_carries", carries, cr);
      chk("rnd_ovf",     {3'b0, overflow}, {3'b0, ov});
      tick();
      if (clear)     mc = 0;
      else if (load) mc = int'(load_count);
      else if (run)  mc = nx;
      chk("rnd_count", count, 4'(mc));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
